param_bank_strobe_gen: RTL and testbench

//  Parametrised synthesizer parameter-bank decoder and write-strobe generator.

---
 rtl/param_bank_strobe_gen_pkg.sv | 26 ++
 rtl/param_bank_strobe_gen_sync_rise_detect.sv | 40 ++++
 rtl/param_bank_strobe_gen.sv | 179 +++++++++++++++++
 tb/tb_param_bank_strobe_gen.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/param_bank_strobe_gen_pkg.sv
`default_nettype none
// ============================================================================
// param_bank_strobe_gen_pkg : bank indices, default population mask, FSM states
// Rev 1.0
// ============================================================================
package param_bank_strobe_gen_pkg;

  localparam int BANK_ENV = 0;
  localparam int BANK_OSC = 1;
  localparam int BANK_M1  = 2;
  localparam int BANK_M2  = 3;
  localparam int BANK_COM = 5;

  localparam logic [5:0] DEFAULT_BANK_MASK = 6'((1 << BANK_ENV) | (1 << BANK_OSC) |
                                                (1 << BANK_M1)  | (1 << BANK_M2)  |
                                                (1 << BANK_COM));

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/param_bank_strobe_gen_sync_rise_detect.sv
`default_nettype none
// ============================================================================
// sync_rise_detect : multi-stage synchroniser with single-cycle rising-edge pulse
// Rev 1.0
// ============================================================================
module sync_rise_detect #(
  parameter int STAGES = 2
) (
  input  logic CLOCK_25,
  input  logic reset,
  input  logic din,
  output logic rise
);

  if (STAGES < 2) begin : g_err_stages
    $error("sync_rise_detect: STAGES must be >= 2");
  end

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] fill_q;
  logic              prev_q;

  // prev stays 1 until the chain holds real samples, so a level held high
  // across reset is never mistaken for a fresh edge.
  always_ff @(posedge CLOCK_25) begin
    if (reset) begin
      sync_q <= '0;
      fill_q <= '0;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      fill_q <= {fill_q[STAGES-2:0], 1'b1};
      prev_q <= fill_q[STAGES-1] ? sync_q[STAGES-1] : 1'b1;
    end
  end

  assign rise = sync_q[STAGES-1] & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/param_bank_strobe_gen.sv
`default_nettype none
// ============================================================================
// param_bank_strobe_gen : parameter-bank decoder and sequenced write-strobe FSM
// Rev 1.0
// ============================================================================
module param_bank_strobe_gen
  import param_bank_strobe_gen_pkg::*;
#(
  parameter int                   ADDR_W      = 3,
  parameter int                   NUM_BANKS   = 6,
  parameter logic [NUM_BANKS-1:0] BANK_MASK   = NUM_BANKS'(DEFAULT_BANK_MASK),
  parameter int                   SYNC_STAGES = 2,
  parameter int                   SETUP_CYC   = 1,
  parameter int                   STROBE_CYC  = 1,
  parameter int                   HOLD_CYC    = 1
) (
  input  logic                 CLOCK_25,
  input  logic                 reset,
  input  logic                 data_ready,
  input  logic [ADDR_W-1:0]    dec_addr,
  output logic [NUM_BANKS-1:0] dec_sel,
  output logic                 read_write,
  output logic                 write_dataenable,
  output logic                 busy,
  output logic                 addr_err,
  output logic                 overrun
);

  if (NUM_BANKS > 2**ADDR_W) begin : g_err_banks
    $error("param_bank_strobe_gen: NUM_BANKS exceeds 2**ADDR_W");
  end
  if (SYNC_STAGES < 2) begin : g_err_sync
    $error("param_bank_strobe_gen: SYNC_STAGES must be >= 2");
  end
  if (SETUP_CYC < 1) begin : g_err_setup
    $error("param_bank_strobe_gen: SETUP_CYC must be >= 1");
  end
  if (STROBE_CYC < 1) begin : g_err_strobe
    $error("param_bank_strobe_gen: STROBE_CYC must be >= 1");
  end
  if (HOLD_CYC < 0) begin : g_err_hold
    $error("param_bank_strobe_gen: HOLD_CYC must be >= 0");
  end

  localparam int c_max_ab  = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int c_max_cyc = (c_max_ab > HOLD_CYC) ? c_max_ab : HOLD_CYC;
  localparam int c_cnt_w   = (c_max_cyc > 1) ? $clog2(c_max_cyc) : 1;
  localparam bit c_has_hold = (HOLD_CYC > 0);

  localparam logic [c_cnt_w-1:0] c_setup_last  = c_cnt_w'(SETUP_CYC - 1);
  localparam logic [c_cnt_w-1:0] c_strobe_last = c_cnt_w'(STROBE_CYC - 1);
  localparam logic [c_cnt_w-1:0] c_hold_last   = c_cnt_w'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

  logic                 w_rise;
  logic                 w_addr_ok;
  logic [NUM_BANKS-1:0] w_onehot;

  state_e               state_q, state_d;
  logic [c_cnt_w-1:0]   cnt_q, cnt_d;
  logic [NUM_BANKS-1:0] sel_q, sel_d;
  logic                 rw_q, rw_d;
  logic                 wde_q, wde_d;
  logic                 ae_q, ae_d;
  logic                 ov_q, ov_d;

  sync_rise_detect #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .CLOCK_25 (CLOCK_25),
    .reset    (reset),
    .din      (data_ready),
    .rise     (w_rise)
  );

  // Out-of-range addresses simply never match a bank index.
  always_comb begin
    w_addr_ok = 1'b0;
    w_onehot  = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (dec_addr == ADDR_W'(i)) begin
        w_onehot[i] = 1'b1;
        w_addr_ok   = BANK_MASK[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    rw_d    = rw_q;
    wde_d   = wde_q;
    ae_d    = 1'b0;
    ov_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (w_rise) begin
          if (w_addr_ok) begin
            sel_d   = w_onehot;
            cnt_d   = '0;
            state_d = ST_SETUP;
          end else begin
            sel_d = '0;
            ae_d  = 1'b1;
          end
        end
      end
      ST_SETUP: begin
        if (cnt_q == c_setup_last) begin
          cnt_d   = '0;
          rw_d    = 1'b1;
          wde_d   = 1'b1;
          state_d = ST_STROBE;
        end else begin
          cnt_d = cnt_q + c_cnt_w'(1);
        end
      end
      ST_STROBE: begin
        if (cnt_q == c_strobe_last) begin
          cnt_d = '0;
          rw_d  = 1'b0;
          if (c_has_hold) begin
            state_d = ST_HOLD;
          end else begin
            wde_d   = 1'b0;
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + c_cnt_w'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == c_hold_last) begin
          cnt_d   = '0;
          wde_d   = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + c_cnt_w'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Requests arriving mid-transfer are flagged and discarded, never queued.
    if (w_rise && (state_q != ST_IDLE)) begin
      ov_d = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_25) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      rw_q    <= 1'b0;
      wde_q   <= 1'b0;
      ae_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      rw_q    <= rw_d;
      wde_q   <= wde_d;
      ae_q    <= ae_d;
      ov_q    <= ov_d;
    end
  end

  assign dec_sel          = sel_q;
  assign read_write       = rw_q;
  assign write_dataenable = wde_q;
  assign busy             = (state_q != ST_IDLE);
  assign addr_err         = ae_q;
  assign overrun          = ov_q;

endmodule
`default_nettype wire

// File: tb/tb_param_bank_strobe_gen.sv
`default_nettype none
// ============================================================================
// tb_param_bank_strobe_gen : cycle-keyed scoreboard bench for the strobe generator
// Rev 1.0
// ============================================================================
module tb_param_bank_strobe_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       dr1, dr2;
  logic [2:0] a1, a2;
  logic [5:0] sel1, sel2;
  logic       rw1, wde1, busy1, ae1, ov1;
  logic       rw2, wde2, busy2, ae2, ov2;

  always #5 clk = ~clk;

  param_bank_strobe_gen u_dut1 (
    .CLOCK_25         (clk),
    .reset            (rst),
    .data_ready       (dr1),
    .dec_addr         (a1),
    .dec_sel          (sel1),
    .read_write       (rw1),
    .write_dataenable (wde1),
    .busy             (busy1),
    .addr_err         (ae1),
    .overrun          (ov1)
  );

  param_bank_strobe_gen #(
    .SETUP_CYC  (3),
    .STROBE_CYC (2),
    .HOLD_CYC   (0)
  ) u_dut2 (
    .CLOCK_25         (clk),
    .reset            (rst),
    .data_ready       (dr2),
    .dec_addr         (a2),
    .dec_sel          (sel2),
    .read_write       (rw2),
    .write_dataenable (wde2),
    .busy             (busy2),
    .addr_err         (ae2),
    .overrun          (ov2)
  );

  // Observed vector: {dec_sel, read_write, write_dataenable, busy, addr_err, overrun}
  logic [10:0] obs1, obs2;
  assign obs1 = {sel1, rw1, wde1, busy1, ae1, ov1};
  assign obs2 = {sel2, rw2, wde2, busy2, ae2, ov2};

  typedef struct {
    int          cyc;
    int          inst;
    string       tag;
    logic [10:0] val;
  } exp_t;

  exp_t       sb[$];
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_err = 0;
  logic [5:0] sel_m1 = 6'b0;
  logic [5:0] sel_m2 = 6'b0;
  logic [5:0] mask_v = 6'h2F;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %b want %b", tag, cyc, obs, exp_v);
    end
  endtask

  function automatic logic [10:0] pk(input logic [5:0] s, input logic rw, input logic wde,
                                     input logic bsy, input logic ae, input logic ov);
    return {s, rw, wde, bsy, ae, ov};
  endfunction

  task automatic push(input int c, input int inst, input string tag, input logic [10:0] v);
    exp_t e;
    e.cyc  = c;
    e.inst = inst;
    e.tag  = tag;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  always @(negedge clk) begin : mon
    exp_t        e;
    logic [10:0] o;
    while (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      o = (e.inst == 1) ? obs1 : obs2;
      chk(e.tag, o, e.val);
    end
  end

  // One request; second_at > 0 re-raises data_ready that many cycles after the first.
  task automatic xfer(input int inst, input int addr, input int second_at);
    int          t, sc, stc, hc, off, len, e_end;
    logic        valid, dr;
    logic [5:0]  old_sel, new_sel;
    logic [10:0] v[0:15];
    t = cyc + 1;
    if (inst == 1) begin
      sc = 1; stc = 1; hc = 1; old_sel = sel_m1;
    end else begin
      sc = 3; stc = 2; hc = 0; old_sel = sel_m2;
    end
    valid = 1'b0;
    if (addr < 6) valid = mask_v[addr];
    new_sel = valid ? (6'b000001 << addr) : 6'b000000;
    for (int i = 0; i < 16; i++) v[i] = pk(new_sel, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    v[1] = pk(old_sel, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    if (valid) begin
      off = 2;
      for (int i = 0; i < sc; i++)  begin v[off] = pk(new_sel, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); off++; end
      for (int i = 0; i < stc; i++) begin v[off] = pk(new_sel, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); off++; end
      for (int i = 0; i < hc; i++)  begin v[off] = pk(new_sel, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0); off++; end
      e_end = off;
    end else begin
      v[2]  = pk(6'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      e_end = 3;
    end
    if (second_at > 0) v[second_at + 2][0] = 1'b1;
    for (int i = 1; i <= e_end + 1; i++)
      push(t + i, inst, $sformatf("x%0d_a%0d_s%0d_o%0d", inst, addr, second_at, i), v[i]);
    len = e_end + 3;
    if (len < 8) len = 8;
    if (second_at > 0 && second_at + 7 > len) len = second_at + 7;
    if (inst == 1) a1 = 3'(addr); else a2 = 3'(addr);
    for (int e = t; e < t + len; e++) begin
      wait_cyc(e - 1);
      off = e - t;
      if (second_at == 0) dr = (off <= 3);
      else dr = (off == 0) || (off >= second_at && off <= second_at + 2);
      if (inst == 1) dr1 = dr; else dr2 = dr;
    end
    wait_cyc(t + len - 1);
    if (inst == 1) sel_m1 = new_sel; else sel_m2 = new_sel;
  endtask

  // Reset lands on the edge after the strobe cycle; data_ready stays high across release.
  task automatic reset_mid();
    int t;
    t  = cyc + 1;
    a1 = 3'd2;
    dr1 = 1'b1;
    push(t + 1, 1, "rst_idle", pk(sel_m1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    push(t + 2, 1, "rst_sel",  pk(6'b000100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    push(t + 3, 1, "rst_strb", pk(6'b000100, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
    push(t + 4, 1, "rst_clr",  pk(6'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    push(t + 4, 2, "rst_clr2", pk(6'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    wait_cyc(t + 3);
    rst = 1'b1;
    for (int c = t + 5; c <= t + 14; c++)
      push(c, 1, $sformatf("rst_hold_%0d", c - t), pk(6'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    wait_cyc(t + 6);
    rst = 1'b0;
    wait_cyc(t + 14);
    dr1 = 1'b0;
    wait_cyc(t + 20);
    sel_m1 = 6'b0;
    sel_m2 = 6'b0;
  endtask

  initial begin
    int fin;
    rst = 1'b1;
    dr1 = 1'b0;
    dr2 = 1'b0;
    a1  = 3'd0;
    a2  = 3'd0;
    wait_cyc(1);
    for (int c = 2; c <= 6; c++) begin
      push(c, 1, "reset1", pk(6'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      push(c, 2, "reset2", pk(6'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    end
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(6);

    xfer(1, 1, 0);
    xfer(1, 4, 0);
    xfer(1, 7, 0);
    xfer(1, 1, 2);
    xfer(1, 3, 3);
    reset_mid();
    xfer(2, 5, 0);
    xfer(1, 0, 0);
    xfer(1, 2, 0);
    xfer(1, 3, 0);
    xfer(1, 5, 0);

    fin = cyc + 3;
    push(fin, 1, "sel_retain", pk(6'b100000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    wait_cyc(fin + 2);
    chk("sb_drain", 11'(sb.size()), 11'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d (want completion)", cyc);
    $fatal(1);
  end

endmodule
`default_nettype wire
